// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencing FSM with memory-ready handshake and bus timeout.
// Optional feature: define MC_BNE_EN to accept bne (branch funct3=001).
module multicycle_controller #(
    parameter int unsigned BUS_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       InstrDone,
    output logic       Error
);

    localparam int unsigned CNT_W   = $clog2(BUS_TIMEOUT + 1);
    localparam int unsigned STATE_W = 4;

    localparam logic [STATE_W-1:0] FETCH    = 4'd0;
    localparam logic [STATE_W-1:0] DECODE   = 4'd1;
    localparam logic [STATE_W-1:0] MEMADR   = 4'd2;
    localparam logic [STATE_W-1:0] MEMREAD  = 4'd3;
    localparam logic [STATE_W-1:0] MEMWB    = 4'd4;
    localparam logic [STATE_W-1:0] MEMWRITE = 4'd5;
    localparam logic [STATE_W-1:0] EXECUTER = 4'd6;
    localparam logic [STATE_W-1:0] EXECUTEI = 4'd7;
    localparam logic [STATE_W-1:0] ALUWB    = 4'd8;
    localparam logic [STATE_W-1:0] BRANCH   = 4'd9;
    localparam logic [STATE_W-1:0] JAL      = 4'd10;
    localparam logic [STATE_W-1:0] ERROR    = 4'd11;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;
    logic [CNT_W-1:0]   wait_cnt;
    logic               wait_state;
    logic               timeout;
    logic [2:0]         alu_dec;
    logic               alu_legal;
    logic               br_legal;
    logic               pc_write_s;
    logic               mem_write_s;
    logic               ir_write_s;
    logic               reg_write_s;
    logic               done_s;

    // ALU operation decode for R/I-type arithmetic
    always_comb begin
        alu_dec   = ALU_ADD;
        alu_legal = 1'b1;
        case (funct3)
            3'b000:  alu_dec = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_dec = ALU_SLT;
            3'b110:  alu_dec = ALU_OR;
            3'b111:  alu_dec = ALU_AND;
            default: alu_legal = 1'b0;
        endcase
    end

`ifdef MC_BNE_EN
    assign br_legal = (funct3 == 3'b000) || (funct3 == 3'b001);
`else
    assign br_legal = (funct3 == 3'b000);
`endif

    // Immediate format follows the opcode in every state
    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_STORE:  ImmSrc = 2'b01;
            OP_BRANCH: ImmSrc = 2'b10;
            OP_JAL:    ImmSrc = 2'b11;
            default:   ImmSrc = 2'b00;
        endcase
    end

    assign wait_state = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
    assign timeout    = wait_state && !MemReady && (wait_cnt == CNT_W'(BUS_TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Consecutive not-ready cycles spent in the current wait state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (!wait_state || MemReady || (state_next != state)) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_next  = state;
        pc_write_s  = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        reg_write_s = 1'b0;
        done_s      = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUControl  = ALU_ADD;
        case (state)
            FETCH: begin
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                ir_write_s = MemReady;
                pc_write_s = MemReady;
                if (MemReady) begin
                    state_next = DECODE;
                end else if (timeout) begin
                    state_next = ERROR;
                end
            end
            DECODE: begin
                // Branch target lands in ALUOut for BRANCH/JAL
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_next = MEMADR;
                    OP_RTYPE:  state_next = alu_legal ? EXECUTER : ERROR;
                    OP_ITYPE:  state_next = alu_legal ? EXECUTEI : ERROR;
                    OP_BRANCH: state_next = br_legal ? BRANCH : ERROR;
                    OP_JAL:    state_next = JAL;
                    default:   state_next = ERROR;
                endcase
            end
            MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                state_next = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                if (MemReady) begin
                    state_next = MEMWB;
                end else if (timeout) begin
                    state_next = ERROR;
                end
            end
            MEMWB: begin
                ResultSrc   = 2'b01;
                reg_write_s = 1'b1;
                done_s      = 1'b1;
                state_next  = FETCH;
            end
            MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_s = 1'b1;
                done_s      = MemReady;
                if (MemReady) begin
                    state_next = FETCH;
                end else if (timeout) begin
                    state_next = ERROR;
                end
            end
            EXECUTER: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_dec;
                state_next = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec;
                state_next = ALUWB;
            end
            ALUWB: begin
                reg_write_s = 1'b1;
                done_s      = 1'b1;
                state_next  = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
`ifdef MC_BNE_EN
                pc_write_s = (funct3 == 3'b001) ? ~Zero : Zero;
`else
                pc_write_s = Zero;
`endif
                done_s     = 1'b1;
                state_next = FETCH;
            end
            JAL: begin
                // PC takes the target in ALUOut while OldPC+4 is computed for rd
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pc_write_s = 1'b1;
                state_next = ALUWB;
            end
            ERROR: begin
                state_next = ERROR;
            end
            default: begin
                state_next = ERROR;
            end
        endcase
    end

    // Enables are held low for the whole time reset is asserted
    assign PCWrite   = pc_write_s  & ~reset;
    assign MemWrite  = mem_write_s & ~reset;
    assign IRWrite   = ir_write_s  & ~reset;
    assign RegWrite  = reg_write_s & ~reset;
    assign InstrDone = done_s      & ~reset;
    assign Error     = (state == ERROR);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed vector bench for multicycle_controller: per-cycle output table plus CPI and timeout sequences.
module tb_multicycle_controller;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    localparam int S_F = 0, S_D = 1, S_MA = 2, S_MR = 3, S_MWB = 4, S_MW = 5;
    localparam int S_EXR = 6, S_EXI = 7, S_WB = 8, S_BR = 9, S_JAL = 10, S_ERR = 11;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic       rw;
        logic [1:0] imm;
        logic [2:0] alu;
        logic       done;
        logic       err;
    } outs_t;

    typedef struct {
        string      name;
        logic       rst;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       zero;
        logic       rdy;
        outs_t      exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic funct7b5, Zero, MemReady;
    logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, InstrDone, Error;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t q[$];

    multicycle_controller #(.BUS_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .InstrDone(InstrDone), .Error(Error)
    );

    always #5 clk = ~clk;

    // Hand-tabulated output pattern of each state; take = expected branch PCWrite
    function automatic outs_t exp_o(int st, logic rdy, logic take, logic [1:0] imm, logic [2:0] alu);
        outs_t e;
        e = '0;
        e.imm = imm;
        case (st)
            S_F:   begin e.pcw = rdy; e.irw = rdy; e.rs = 2'b10; e.sb = 2'b10; end
            S_D:   begin e.sa = 2'b01; e.sb = 2'b01; end
            S_MA:  begin e.sa = 2'b10; e.sb = 2'b01; end
            S_MR:  begin e.adr = 1'b1; end
            S_MWB: begin e.rs = 2'b01; e.rw = 1'b1; e.done = 1'b1; end
            S_MW:  begin e.adr = 1'b1; e.mw = 1'b1; e.done = rdy; end
            S_EXR: begin e.sa = 2'b10; e.alu = alu; end
            S_EXI: begin e.sa = 2'b10; e.sb = 2'b01; e.alu = alu; end
            S_WB:  begin e.rw = 1'b1; e.done = 1'b1; end
            S_BR:  begin e.sa = 2'b10; e.alu = 3'b001; e.pcw = take; e.done = 1'b1; end
            S_JAL: begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
            default: begin e.err = 1'b1; end
        endcase
        return e;
    endfunction

    task automatic add(string n, int st, logic r, logic [6:0] o, logic [2:0] f, logic f7,
                       logic z, logic rdy, logic [1:0] imm, logic [2:0] alu, logic take);
        vec_t v;
        v.name = n; v.rst = r; v.op = o; v.f3 = f; v.f7 = f7; v.zero = z; v.rdy = rdy;
        v.exp = exp_o(st, r ? 1'b0 : rdy, take, imm, alu);
        q.push_back(v);
    endtask

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Run one instruction from reset and count cycles up to its InstrDone
    task automatic cpi_run(string n, logic [6:0] o, logic [2:0] f, int exp_cycles);
        int found;
        found = 0;
        op = o; funct3 = f; funct7b5 = 1'b0; Zero = 1'b1; MemReady = 1'b1;
        do_reset();
        for (int c = 1; c <= 20 && found == 0; c++) begin
            @(negedge clk);
            if (InstrDone) found = c;
            @(posedge clk);
            #1;
        end
        chk(n, 32'(found), 32'(exp_cycles));
    endtask

    initial begin
        outs_t act;
        int err_at;
        reset = 1'b1; op = OP_R; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b1;

        add("reset",    S_F,   1, OP_R, 3'b000, 0, 0, 1, 2'b00, 3'b000, 0);
        add("add_f",    S_F,   0, OP_R, 3'b000, 0, 0, 1, 2'b00, 3'b000, 0);
        add("add_d",    S_D,   0, OP_R, 3'b000, 0, 0, 1, 2'b00, 3'b000, 0);
        add("add_ex",   S_EXR, 0, OP_R, 3'b000, 0, 0, 1, 2'b00, 3'b000, 0);
        add("add_wb",   S_WB,  0, OP_R, 3'b000, 0, 0, 1, 2'b00, 3'b000, 0);
        add("sub_f",    S_F,   0, OP_R, 3'b000, 1, 0, 1, 2'b00, 3'b000, 0);
        add("sub_d",    S_D,   0, OP_R, 3'b000, 1, 0, 1, 2'b00, 3'b000, 0);
        add("sub_ex",   S_EXR, 0, OP_R, 3'b000, 1, 0, 1, 2'b00, 3'b001, 0);
        add("sub_wb",   S_WB,  0, OP_R, 3'b000, 1, 0, 1, 2'b00, 3'b000, 0);
        add("and_f",    S_F,   0, OP_R, 3'b111, 0, 0, 1, 2'b00, 3'b000, 0);
        add("and_d",    S_D,   0, OP_R, 3'b111, 0, 0, 1, 2'b00, 3'b000, 0);
        add("and_ex",   S_EXR, 0, OP_R, 3'b111, 0, 0, 1, 2'b00, 3'b010, 0);
        add("and_wb",   S_WB,  0, OP_R, 3'b111, 0, 0, 1, 2'b00, 3'b000, 0);
        add("slti_f",   S_F,   0, OP_I, 3'b010, 1, 0, 1, 2'b00, 3'b000, 0);
        add("slti_d",   S_D,   0, OP_I, 3'b010, 1, 0, 1, 2'b00, 3'b000, 0);
        add("slti_ex",  S_EXI, 0, OP_I, 3'b010, 1, 0, 1, 2'b00, 3'b101, 0);
        add("slti_wb",  S_WB,  0, OP_I, 3'b010, 1, 0, 1, 2'b00, 3'b000, 0);
        add("addi_f",   S_F,   0, OP_I, 3'b000, 1, 0, 1, 2'b00, 3'b000, 0);
        add("addi_d",   S_D,   0, OP_I, 3'b000, 1, 0, 1, 2'b00, 3'b000, 0);
        add("addi_ex",  S_EXI, 0, OP_I, 3'b000, 1, 0, 1, 2'b00, 3'b000, 0);
        add("addi_wb",  S_WB,  0, OP_I, 3'b000, 1, 0, 1, 2'b00, 3'b000, 0);
        add("ori_f",    S_F,   0, OP_I, 3'b110, 0, 0, 1, 2'b00, 3'b000, 0);
        add("ori_d",    S_D,   0, OP_I, 3'b110, 0, 0, 1, 2'b00, 3'b000, 0);
        add("ori_ex",   S_EXI, 0, OP_I, 3'b110, 0, 0, 1, 2'b00, 3'b011, 0);
        add("ori_wb",   S_WB,  0, OP_I, 3'b110, 0, 0, 1, 2'b00, 3'b000, 0);
        add("lw_f",     S_F,   0, OP_LW, 3'b010, 0, 0, 1, 2'b00, 3'b000, 0);
        add("lw_d",     S_D,   0, OP_LW, 3'b010, 0, 0, 1, 2'b00, 3'b000, 0);
        add("lw_ma",    S_MA,  0, OP_LW, 3'b010, 0, 0, 1, 2'b00, 3'b000, 0);
        for (int i = 0; i < 3; i++)
            add("lw_wait", S_MR, 0, OP_LW, 3'b010, 0, 0, 0, 2'b00, 3'b000, 0);
        add("lw_mr",    S_MR,  0, OP_LW, 3'b010, 0, 0, 1, 2'b00, 3'b000, 0);
        add("lw_wb",    S_MWB, 0, OP_LW, 3'b010, 0, 0, 1, 2'b00, 3'b000, 0);
        add("sw_f",     S_F,   0, OP_SW, 3'b010, 0, 0, 1, 2'b01, 3'b000, 0);
        add("sw_d",     S_D,   0, OP_SW, 3'b010, 0, 0, 1, 2'b01, 3'b000, 0);
        add("sw_ma",    S_MA,  0, OP_SW, 3'b010, 0, 0, 1, 2'b01, 3'b000, 0);
        for (int i = 0; i < 2; i++)
            add("sw_wait", S_MW, 0, OP_SW, 3'b010, 0, 0, 0, 2'b01, 3'b000, 0);
        add("sw_mw",    S_MW,  0, OP_SW, 3'b010, 0, 0, 1, 2'b01, 3'b000, 0);
        add("beq1_f",   S_F,   0, OP_BR, 3'b000, 0, 1, 1, 2'b10, 3'b000, 0);
        add("beq1_d",   S_D,   0, OP_BR, 3'b000, 0, 1, 1, 2'b10, 3'b000, 0);
        add("beq1_br",  S_BR,  0, OP_BR, 3'b000, 0, 1, 1, 2'b10, 3'b000, 1);
        add("beq0_f",   S_F,   0, OP_BR, 3'b000, 0, 0, 1, 2'b10, 3'b000, 0);
        add("beq0_d",   S_D,   0, OP_BR, 3'b000, 0, 0, 1, 2'b10, 3'b000, 0);
        add("beq0_br",  S_BR,  0, OP_BR, 3'b000, 0, 0, 1, 2'b10, 3'b000, 0);
        add("jal_f",    S_F,   0, OP_JAL, 3'b000, 0, 0, 1, 2'b11, 3'b000, 0);
        add("jal_d",    S_D,   0, OP_JAL, 3'b000, 0, 0, 1, 2'b11, 3'b000, 0);
        add("jal_j",    S_JAL, 0, OP_JAL, 3'b000, 0, 0, 1, 2'b11, 3'b000, 0);
        add("jal_wb",   S_WB,  0, OP_JAL, 3'b000, 0, 0, 1, 2'b11, 3'b000, 0);
        // 14 not-ready cycles is one short of the timeout
        add("lw14_f",   S_F,   0, OP_LW, 3'b010, 0, 0, 1, 2'b00, 3'b000, 0);
        add("lw14_d",   S_D,   0, OP_LW, 3'b010, 0, 0, 1, 2'b00, 3'b000, 0);
        add("lw14_ma",  S_MA,  0, OP_LW, 3'b010, 0, 0, 1, 2'b00, 3'b000, 0);
        for (int i = 0; i < 14; i++)
            add("lw14_wait", S_MR, 0, OP_LW, 3'b010, 0, 0, 0, 2'b00, 3'b000, 0);
        add("lw14_mr",  S_MR,  0, OP_LW, 3'b010, 0, 0, 1, 2'b00, 3'b000, 0);
        add("lw14_wb",  S_MWB, 0, OP_LW, 3'b010, 0, 0, 1, 2'b00, 3'b000, 0);
        for (int i = 0; i < 15; i++)
            add("to_fetch", S_F, 0, OP_R, 3'b000, 0, 0, 0, 2'b00, 3'b000, 0);
        add("to_err1",  S_ERR, 0, OP_R, 3'b000, 0, 0, 1, 2'b00, 3'b000, 0);
        add("to_err2",  S_ERR, 0, OP_JAL, 3'b000, 0, 1, 1, 2'b11, 3'b000, 0);
        add("to_rst",   S_F,   1, OP_R, 3'b000, 0, 0, 1, 2'b00, 3'b000, 0);
        add("to_f",     S_F,   0, OP_BAD, 3'b000, 0, 0, 1, 2'b00, 3'b000, 0);
        add("bad_d",    S_D,   0, OP_BAD, 3'b000, 0, 0, 1, 2'b00, 3'b000, 0);
        add("bad_err",  S_ERR, 0, OP_BAD, 3'b000, 0, 0, 1, 2'b00, 3'b000, 0);
        add("bad_rst",  S_F,   1, OP_R, 3'b001, 0, 0, 1, 2'b00, 3'b000, 0);
        add("sll_f",    S_F,   0, OP_R, 3'b001, 0, 0, 1, 2'b00, 3'b000, 0);
        add("sll_d",    S_D,   0, OP_R, 3'b001, 0, 0, 1, 2'b00, 3'b000, 0);
        add("sll_err",  S_ERR, 0, OP_R, 3'b001, 0, 0, 1, 2'b00, 3'b000, 0);
        add("sll_rst",  S_F,   1, OP_BR, 3'b001, 0, 0, 1, 2'b10, 3'b000, 0);
        add("bne_f",    S_F,   0, OP_BR, 3'b001, 0, 0, 1, 2'b10, 3'b000, 0);
        add("bne_d",    S_D,   0, OP_BR, 3'b001, 0, 0, 1, 2'b10, 3'b000, 0);
`ifdef MC_BNE_EN
        add("bne_br",   S_BR,  0, OP_BR, 3'b001, 0, 0, 1, 2'b10, 3'b000, 1);
`else
        add("bne_err",  S_ERR, 0, OP_BR, 3'b001, 0, 0, 1, 2'b10, 3'b000, 0);
`endif
        add("bne_rst",  S_F,   1, OP_SW, 3'b010, 0, 0, 1, 2'b01, 3'b000, 0);
        add("swr_f",    S_F,   0, OP_SW, 3'b010, 0, 0, 1, 2'b01, 3'b000, 0);
        add("swr_d",    S_D,   0, OP_SW, 3'b010, 0, 0, 1, 2'b01, 3'b000, 0);
        add("swr_ma",   S_MA,  0, OP_SW, 3'b010, 0, 0, 1, 2'b01, 3'b000, 0);
        add("swr_wait", S_MW,  0, OP_SW, 3'b010, 0, 0, 0, 2'b01, 3'b000, 0);
        add("swr_rst",  S_F,   1, OP_SW, 3'b010, 0, 0, 1, 2'b01, 3'b000, 0);
        add("swr_f2",   S_F,   0, OP_SW, 3'b010, 0, 0, 1, 2'b01, 3'b000, 0);

        @(posedge clk);
        #1;
        foreach (q[i]) begin
            reset = q[i].rst; op = q[i].op; funct3 = q[i].f3; funct7b5 = q[i].f7;
            Zero = q[i].zero; MemReady = q[i].rdy;
            @(negedge clk);
            act = '{PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                    RegWrite, ImmSrc, ALUControl, InstrDone, Error};
            chk(q[i].name, 32'(act), 32'(q[i].exp));
            @(posedge clk);
            #1;
        end

        cpi_run("cpi_lw",  OP_LW,  3'b010, 5);
        cpi_run("cpi_sw",  OP_SW,  3'b010, 4);
        cpi_run("cpi_r",   OP_R,   3'b000, 4);
        cpi_run("cpi_i",   OP_I,   3'b000, 4);
        cpi_run("cpi_beq", OP_BR,  3'b000, 3);
        cpi_run("cpi_jal", OP_JAL, 3'b000, 4);

        // Fetch timeout: 15 not-ready FETCH cycles, Error visible on the 16th
        op = OP_R; funct3 = 3'b000; MemReady = 1'b0;
        do_reset();
        err_at = 0;
        for (int c = 1; c <= 40 && err_at == 0; c++) begin
            @(negedge clk);
            if (Error) err_at = c;
            @(posedge clk);
            #1;
        end
        chk("timeout_cycle", 32'(err_at), 32'd16);
        MemReady = 1'b1;
        @(negedge clk);
        chk("err_sticky", {31'd0, Error}, 32'd1);
        chk("err_enables", {27'd0, PCWrite, IRWrite, RegWrite, MemWrite, InstrDone}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("err_cleared", {31'd0, Error}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing control unit for the multicycle RV32I core: a Moore FSM that steps the shared datapath (one ALU, one unified memory port, instruction/data registers) through fetch, decode, execute, memory and writeback. It reuses the main/ALU decode conventions of the single-cycle `controller` and adds a memory-ready handshake with a bus timeout. It sits between the instruction register fields and the datapath mux/enable inputs.

## Interface
- `BUS_TIMEOUT`, 15, consecutive not-ready cycles tolerated in a memory-wait state before faulting (legal range ≥1)
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `op`  in  7  opcode from instruction register
- `funct3`  in  3  instruction funct3
- `funct7b5`  in  1  instruction bit 30
- `Zero`  in  1  ALU zero flag
- `MemReady`  in  1  memory completes current access this cycle
- `PCWrite`  out  1  PC register enable
- `AdrSrc`  out  1  memory address: 0=PC, 1=ALUOut
- `MemWrite`  out  1  memory write strobe
- `IRWrite`  out  1  instruction register / OldPC enable
- `ResultSrc`  out  2  00=ALUOut, 01=Data, 10=ALUResult
- `ALUSrcA`  out  2  00=PC, 01=OldPC, 10=rs1
- `ALUSrcB`  out  2  00=rs2, 01=ImmExt, 10=const 4
- `RegWrite`  out  1  register file write enable
- `ImmSrc`  out  2  immediate format: 00=I, 01=S, 10=B, 11=J
- `ALUControl`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- `InstrDone`  out  1  one-cycle pulse on final cycle of each instruction
- `Error`  out  1  sticky fault flag

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, ERROR.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10; IRWrite=PCWrite=MemReady; to DECODE when MemReady, else stay.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch target into ALUOut). Next by op: 0000011/0100011→MEMADR, 0110011→EXECUTER, 0010011→EXECUTEI, 1100011→BRANCH, 1101111→JAL, other→ERROR.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add; →MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: AdrSrc=1; →MEMWB on MemReady. MEMWB: ResultSrc=01, RegWrite=1, InstrDone=1; →FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 held until MemReady; InstrDone=MemReady; →FETCH on MemReady.
- EXECUTER/EXECUTEI: ALUSrcA=10, ALUSrcB=00/01, ALU-op decode; →ALUWB. ALUWB: ResultSrc=00, RegWrite=1, InstrDone=1; →FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00; PCWrite=Zero for beq; InstrDone=1; →FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1; →ALUWB.
- ALU-op decode: funct3 000→sub if op[5]&funct7b5 else add; 010→slt; 110→or; 111→and; other→ERROR at decode.
- ImmSrc: combinational from op regardless of state (I-type/load 00, store 01, branch 10, jal 11, other 00).
- Timeout: counter increments each cycle in FETCH/MEMREAD/MEMWRITE with MemReady=0; clears on any state change or MemReady=1. On the BUS_TIMEOUT-th consecutive not-ready cycle, next state ERROR.
- ERROR: all enables (PCWrite, IRWrite, RegWrite, MemWrite, InstrDone) 0, Error=1; exit only by reset.

## Timing
- Reset: state=FETCH, counter=0, Error=0; while reset high PCWrite/IRWrite/RegWrite/MemWrite/InstrDone forced 0.
- Outputs are Moore (state decode) except MemReady/Zero-gated enables, which are same-cycle combinational.
- CPI with MemReady tied 1: lw 5, sw 4, R/I-type 4, branch 3, jal 4.
- Each not-ready cycle in a wait state adds one cycle; no enable other than MemWrite asserts while waiting.
- Reset mid-instruction: abandon immediately, no partial write completes after reset deasserts.

## Configuration
- `MC_BNE_EN`: defined → op 1100011 funct3=001 (bne) legal, BRANCH uses PCWrite=!Zero. Undefined → only funct3=000 legal; any other branch funct3 goes DECODE→ERROR.

## Test plan
- Reset then R-type add (op=0110011, f3=000, f7b5=0), MemReady=1 → FETCH,DECODE,EXECUTER,ALUWB; ALUWB: RegWrite=1, ALUControl=000, InstrDone=1; 4 cycles.
- lw (op=0000011, f3=010), MemReady low 3 cycles in MEMREAD → 8 cycles total, MemWB RegWrite=1 ResultSrc=01, ImmSrc=00.
- sw (op=0100011) → MEMWRITE MemWrite=1 AdrSrc=1 held until MemReady, ImmSrc=01, RegWrite never 1.
- beq Zero=1 then Zero=0 → BRANCH PCWrite=1 / 0, ALUControl=001, ImmSrc=10, 3 cycles each.
- MemReady held 0 in FETCH for 15 cycles → ERROR, Error=1, enables 0 until reset; reset clears Error, returns FETCH.
- op=1111111 or bne with macro undefined → ERROR after DECODE; bne with `MC_BNE_EN`, Zero=0 → PCWrite=1.
